// File: rtl/seu_test_pkg.sv
// -----------------------------------------------------------------------------
// seu_test_pkg
// Shared definitions for the SEU shift-register chain tester:
//   - state_t      : FSM state encoding (IDLE=0 .. DONE=4)
//   - PAT_*        : pattern_sel codes
//   - pat()        : expected chain bit for readout/fill index k
// -----------------------------------------------------------------------------
package seu_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL    = 3'd1,
    ST_HOLD    = 3'd2,
    ST_READOUT = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [1:0] PAT_ZEROS = 2'd0;  // every bit 0
  localparam logic [1:0] PAT_ONES  = 2'd1;  // every bit 1
  localparam logic [1:0] PAT_ALT   = 2'd2;  // bit k = k[0]
  localparam logic [1:0] PAT_ALT_N = 2'd3;  // bit k = ~k[0]

  // All supported patterns depend on k only through its LSB, so only that
  // bit is passed in.
  function automatic logic pat(input logic k_lsb, input logic [1:0] sel);
    logic b;
    case (sel)
      PAT_ZEROS: b = 1'b0;
      PAT_ONES:  b = 1'b1;
      PAT_ALT:   b = k_lsb;
      PAT_ALT_N: b = ~k_lsb;
      default:   b = 1'b0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/seu_pattern_gen.sv
// -----------------------------------------------------------------------------
// seu_pattern_gen
// Combinational pattern bit generator, used for both chain fill and readout
// comparison so the two can never disagree on the pattern definition.
// Ports:
//   k_lsb_i : LSB of the bit index k
//   sel_i   : pattern select code (PAT_*)
//   pat_o   : pattern bit pat(k, sel)
// -----------------------------------------------------------------------------
module seu_pattern_gen
  import seu_test_pkg::*;
(
  input  logic       k_lsb_i,
  input  logic [1:0] sel_i,
  output logic       pat_o
);

  assign pat_o = pat(k_lsb_i, sel_i);

endmodule

// File: rtl/seu_shift_reg_tester.sv
// -----------------------------------------------------------------------------
// seu_shift_reg_tester
// Fills an SEU test shift-register chain with a known pattern, holds it static
// for hold_cycles exposure cycles, then shifts it out (reloading the same
// pattern behind it) and counts every bit that no longer matches.
//
// Optional build macro: SEU_SHIFT_REG_TESTER_CONT_EN
//   defined   : after each readout, pulse done and go straight back to HOLD,
//               looping until abort; errors accumulate across loops.
//   undefined : single run IDLE -> FILL -> HOLD -> READOUT -> DONE -> IDLE.
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   start               : begin a run (sampled in IDLE only)
//   abort               : return to IDLE next cycle, results frozen
//   pattern_sel         : pattern code, latched at start
//   hold_cycles         : exposure length, latched at start
//   sr_data_in, sr_mode : serial data / shift enable into the chain
//   sr_data_out         : chain MSB
//   busy, done          : status; done is a one-cycle pulse
//   err_count, err_flag : mismatch count (saturating) and any-mismatch flag
//   first_err_idx       : readout index of the first mismatch
// -----------------------------------------------------------------------------
module seu_shift_reg_tester
  import seu_test_pkg::*;
#(
  parameter int LENGTH = 50,
  parameter int HOLD_W = 16,
  parameter int CNT_W  = 8,
  parameter int IDX_W  = $clog2(LENGTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        pattern_sel,
  input  logic [HOLD_W-1:0] hold_cycles,
  output logic              sr_data_in,
  output logic              sr_mode,
  input  logic              sr_data_out,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  err_count,
  output logic              err_flag,
  output logic [IDX_W-1:0]  first_err_idx
);

  localparam logic [IDX_W-1:0] K_LAST = IDX_W'(LENGTH - 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    k_q, k_d;
  logic [HOLD_W-1:0]   hcnt_q, hcnt_d;
  logic [1:0]          sel_q, sel_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]    err_count_q, err_count_d;
  logic                err_flag_q, err_flag_d;
  logic [IDX_W-1:0]    first_idx_q, first_idx_d;
  logic                sr_mode_q, sr_mode_d;
  logic                sr_data_in_q, sr_data_in_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                pat_fill;
  logic                pat_cmp;

  // The fill generator looks at next-state index/select because sr_data_in
  // is registered: the bit shifted at an edge must already be on the pin.
  seu_pattern_gen u_pat_fill (
    .k_lsb_i (k_d[0]),
    .sel_i   (sel_d),
    .pat_o   (pat_fill)
  );

  // The compare generator uses the current index: sr_data_out is the
  // pre-shift chain MSB, so no pipeline alignment is needed.
  seu_pattern_gen u_pat_cmp (
    .k_lsb_i (k_q[0]),
    .sel_i   (sel_q),
    .pat_o   (pat_cmp)
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    hcnt_d      = hcnt_q;
    sel_d       = sel_q;
    hold_d      = hold_q;
    err_count_d = err_count_q;
    err_flag_d  = err_flag_q;
    first_idx_d = first_idx_q;
    done_d      = 1'b0;

    if (state_q != ST_IDLE && abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            sel_d       = pattern_sel;
            hold_d      = hold_cycles;
            err_count_d = '0;
            err_flag_d  = 1'b0;
            first_idx_d = '0;
            k_d         = '0;
            state_d     = ST_FILL;
          end
        end

        ST_FILL: begin
          if (k_q == K_LAST) begin
            k_d     = '0;
            hcnt_d  = '0;
            state_d = (hold_q == '0) ? ST_READOUT : ST_HOLD;
          end else begin
            k_d = k_q + 1'b1;
          end
        end

        ST_HOLD: begin
          if (hcnt_q == hold_q - 1'b1) begin
            k_d     = '0;
            state_d = ST_READOUT;
          end else begin
            hcnt_d = hcnt_q + 1'b1;
          end
        end

        ST_READOUT: begin
          if (sr_data_out != pat_cmp) begin
            if (err_count_q != '1) begin
              err_count_d = err_count_q + 1'b1;
            end
            if (!err_flag_q) begin
              err_flag_d  = 1'b1;
              first_idx_d = k_q;
            end
          end
          if (k_q == K_LAST) begin
            done_d = 1'b1;
            k_d    = '0;
            hcnt_d = '0;
`ifdef SEU_SHIFT_REG_TESTER_CONT_EN
            // Readout reloaded the pattern, so the chain is ready for
            // another exposure without a fresh fill.
            state_d = (hold_q == '0) ? ST_READOUT : ST_HOLD;
`else
            state_d = ST_DONE;
`endif
          end else begin
            k_d = k_q + 1'b1;
          end
        end

        ST_DONE: begin
          state_d = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign sr_mode_d    = (state_d == ST_FILL) || (state_d == ST_READOUT);
  assign sr_data_in_d = sr_mode_d & pat_fill;
  assign busy_d       = (state_d != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      hcnt_q       <= '0;
      sel_q        <= '0;
      hold_q       <= '0;
      err_count_q  <= '0;
      err_flag_q   <= 1'b0;
      first_idx_q  <= '0;
      sr_mode_q    <= 1'b0;
      sr_data_in_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      hcnt_q       <= hcnt_d;
      sel_q        <= sel_d;
      hold_q       <= hold_d;
      err_count_q  <= err_count_d;
      err_flag_q   <= err_flag_d;
      first_idx_q  <= first_idx_d;
      sr_mode_q    <= sr_mode_d;
      sr_data_in_q <= sr_data_in_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
    end
  end

  assign sr_data_in    = sr_data_in_q;
  assign sr_mode       = sr_mode_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_count     = err_count_q;
  assign err_flag      = err_flag_q;
  assign first_err_idx = first_idx_q;

endmodule

// File: tb/tb_seu_shift_reg_tester.sv
// -----------------------------------------------------------------------------
// tb_seu_shift_reg_tester
// Bench for seu_shift_reg_tester with a behavioural chain beside the DUT.
// Expected results come from the pattern rules and the set of flipped chain
// bits: chain bit b holds pattern index LENGTH-1-b after the fill.
// -----------------------------------------------------------------------------
module tb_seu_shift_reg_tester;

  localparam int L   = 50;
  localparam int HW  = 16;
  localparam int CW  = 8;
  localparam int IW  = $clog2(L);
  localparam int L2  = 8;
  localparam int CW2 = 2;
  localparam int IW2 = $clog2(L2);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    pattern_sel = 2'd0;
  logic [HW-1:0] hold_cycles = '0;
  logic          sr_data_in, sr_mode, sr_data_out, busy, done, err_flag;
  logic [CW-1:0] err_count;
  logic [IW-1:0] first_err_idx;

  // Behavioural chain: shifts towards the MSB when enabled; while frozen the
  // bench can flip bits through inj_mask to emulate upsets.
  logic [L-1:0] chain = '0;
  logic [L-1:0] inj_mask = '0;
  always @(posedge clk) begin
    if (sr_mode) chain <= {chain[L-2:0], sr_data_in};
    else         chain <= chain ^ inj_mask;
  end
  assign sr_data_out = chain[L-1];

  seu_shift_reg_tester #(.LENGTH(L), .HOLD_W(HW), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .pattern_sel   (pattern_sel),
    .hold_cycles   (hold_cycles),
    .sr_data_in    (sr_data_in),
    .sr_mode       (sr_mode),
    .sr_data_out   (sr_data_out),
    .busy          (busy),
    .done          (done),
    .err_count     (err_count),
    .err_flag      (err_flag),
    .first_err_idx (first_err_idx)
  );

  // Small instance with a stuck-at-1 chain output to reach counter saturation.
  logic           start2 = 1'b0;
  logic           sr_data_in2, sr_mode2, busy2, done2, err_flag2;
  logic [CW2-1:0] err_count2;
  logic [IW2-1:0] first2;

  seu_shift_reg_tester #(.LENGTH(L2), .HOLD_W(HW), .CNT_W(CW2)) dut_sat (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start2),
    .abort         (1'b0),
    .pattern_sel   (2'd0),
    .hold_cycles   (16'd3),
    .sr_data_in    (sr_data_in2),
    .sr_mode       (sr_mode2),
    .sr_data_out   (1'b1),
    .busy          (busy2),
    .done          (done2),
    .err_count     (err_count2),
    .err_flag      (err_flag2),
    .first_err_idx (first2)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit model_pat(input int k, input int sel);
    case (sel)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (k % 2) == 1;
      default: return (k % 2) == 0;
    endcase
  endfunction

  // Chain contents expected after a complete fill or readout.
  function automatic logic [L-1:0] model_image(input int sel);
    logic [L-1:0] img;
    for (int k = 0; k < L; k++) img[L-1-k] = model_pat(k, sel);
    return img;
  endfunction

  // kind: 0 = complete run, 1 = abort sampled at stop_edge,
  //       2 = reset sampled at stop_edge. Edge 0 is the one that takes start.
  task automatic run_one(input int sel, input int hold, input logic [L-1:0] mask,
                         input int kind, input int stop_edge);
    int n, done_edge, j, exp_cnt, exp_first, any_done;
    bit stopped;
    logic [1:0] s;
    logic [L-1:0] eff_mask;
    s = 2'(sel);
    @(negedge clk);
    start       = 1'b1;
    pattern_sel = s;
    hold_cycles = HW'(hold);
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0; done_edge = -1; stopped = 0;
    while (done_edge < 0 && !stopped && n < 2*L + hold + 5) begin
      inj_mask = (hold > 0 && n == L) ? mask : '0;
      abort    = (kind == 1 && n == stop_edge - 1);
      rst_n    = !(kind == 2 && n == stop_edge - 1);
      // A stray start (with another pattern) mid-run must be ignored.
      start       = (n == 3);
      pattern_sel = (n == 3) ? ~s : s;
      @(posedge clk);
      #1;
      n++;
      if (n == 1) check_eq("busy_in_run", int'(busy), 1);
      if (done) done_edge = n;
      if (kind != 0 && n == stop_edge) stopped = 1;
    end
    inj_mask = '0; abort = 1'b0; rst_n = 1'b1; start = 1'b0; pattern_sel = s;

    // Readout index k is compared at edge L+hold+1+k.
    eff_mask = (hold > 0) ? mask : '0;
    j = (kind == 0) ? L : stop_edge - (L + hold + 1);
    exp_cnt = 0; exp_first = -1;
    for (int k = 0; k < L; k++) begin
      if (k < j && eff_mask[L-1-k]) begin
        exp_cnt++;
        if (exp_first < 0) exp_first = k;
      end
    end
    if (exp_cnt > 255) exp_cnt = 255;

    if (kind == 2) begin
      check_eq("reset_outputs",
               int'({sr_mode, sr_data_in, busy, done, err_flag, err_count, first_err_idx}), 0);
    end else begin
      if (kind == 0) begin
        check_eq("latency", done_edge, 2*L + hold);
        check_eq("mode_at_done", int'(sr_mode), 0);
      end else begin
        check_eq("abort_idle", int'({busy, sr_mode, done}), 0);
        check_eq("abort_stopped", int'(stopped), 1);
      end
      check_eq("err_count", int'(err_count), exp_cnt);
      check_eq("err_flag", int'(err_flag), int'(exp_cnt > 0));
      if (exp_cnt > 0) check_eq("first_err_idx", int'(first_err_idx), exp_first);
    end

    any_done = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      any_done |= int'(done);
    end
    check_eq("idle_after", int'({busy, any_done[0]}), 0);
    if (kind == 0) check_eq("chain_reloaded", $countones(chain ^ model_image(sel)), 0);

    $display("run sel=%0d hold=%0d kind=%0d stop=%0d flips=%0d -> done_edge=%0d lat=%0d errs=%0d flag=%0d first=%0d (exp errs=%0d first=%0d)",
             sel, hold, kind, stop_edge, $countones(eff_mask), done_edge,
             (done_edge < 0) ? -1 : done_edge + 2, err_count, err_flag,
             first_err_idx, exp_cnt, exp_first);
  endtask

  function automatic logic [L-1:0] rand_mask();
    logic [L-1:0] m;
    int nb;
    m  = '0;
    nb = $urandom_range(0, 3);
    for (int i = 0; i < nb; i++) m[$urandom_range(0, L-1)] = 1'b1;
    return m;
  endfunction

  initial begin
    int n2, d2, sel, hold, kind, r;
    logic [L-1:0] m;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_state",
             int'({sr_mode, sr_data_in, busy, done, err_flag, err_count, first_err_idx}), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases from the test plan.
    run_one(2, 10, '0, 0, 0);
    m = '0; m[37] = 1'b1;
    run_one(2, 10, m, 0, 0);
    m = '0; m[5] = 1'b1; m[20] = 1'b1; m[44] = 1'b1;
    run_one(1, 10, m, 0, 0);
    run_one(3, 0, '0, 0, 0);
    run_one(3, 0, '0, 0, 0);
    run_one(2, 10, '0, 1, L + 4);                     // abort in HOLD
    m = '0; m[49] = 1'b1; m[40] = 1'b1; m[10] = 1'b1;
    run_one(0, 10, m, 1, L + 10 + 1 + 20);           // abort mid-READOUT
    run_one(0, 10, m, 2, L + 10 + 1 + 20);           // reset mid-READOUT
    run_one(0, 10, m, 0, 0);                         // clean run after reset

    // Saturation on the small instance: all 8 readout bits mismatch.
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    n2 = 0; d2 = -1;
    while (d2 < 0 && n2 < 2*L2 + 3 + 5) begin
      @(posedge clk);
      #1;
      n2++;
      if (done2) d2 = n2;
    end
    check_eq("sat_latency", d2, 2*L2 + 3);
    check_eq("sat_err_count", int'(err_count2), 3);
    check_eq("sat_err_flag", int'(err_flag2), 1);
    check_eq("sat_first_idx", int'(first2), 0);
    @(posedge clk);
    #1;
    check_eq("sat_idle", int'({busy2, sr_mode2, sr_data_in2, done2}), 0);
    $display("run sat L=%0d -> done_edge=%0d errs=%0d flag=%0d first=%0d",
             L2, d2, err_count2, err_flag2, first2);

    // Randomised runs.
    for (int t = 0; t < 14; t++) begin
      sel  = $urandom_range(0, 3);
      hold = $urandom_range(0, 20);
      m    = rand_mask();
      r    = $urandom_range(0, 5);
      kind = (r < 3) ? 0 : ((r == 3 || r == 4) ? 1 : 2);
      run_one(sel, hold, m, kind, $urandom_range(5, 2*L + hold));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seu_shift_reg_tester.md
Name: seu_shift_reg_tester

Overview:
- Drives and checks an SEU test shift-register chain: serial data in, mode/shift-enable, serial data out taken from MSB.
- Fills the chain with a known pattern, holds it static for a programmable exposure window, then shifts it out and compares every bit against the expected pattern.
- Reports the mismatch (SEU) count and the index of the first upset bit.
- Sits beside each chain instance in the SEU test structure; results are read by slow control.

Parameters:
- LENGTH, 50, chain length in bits; must match the chain under test; must be ≥ 2.
- HOLD_W, 16, width of the hold-cycle count.
- CNT_W, 8, width of the error counter.
- IDX_W, $clog2(LENGTH), width of the bit-index counter and first_err_idx.

Ports:
- clk  in  1  system clock (same clock as the chain).
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin a test run; sampled only in IDLE.
- abort  in  1  return to IDLE next cycle; results are frozen.
- pattern_sel  in  2  0=all-0, 1=all-1, 2=bit k = k[0], 3=bit k = ~k[0].
- hold_cycles  in  HOLD_W  number of exposure cycles with the chain frozen.
- sr_data_in  out  1  serial data into the chain.
- sr_mode  out  1  chain shift enable.
- sr_data_out  in  1  chain serial output (chain MSB).
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when readout completes.
- err_count  out  CNT_W  mismatches in the last run; saturates at all-ones.
- err_flag  out  1  at least one mismatch in the last run.
- first_err_idx  out  IDX_W  readout index k of the first mismatch; valid only when err_flag=1.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE.
  - sr_mode, sr_data_in, busy, done, err_flag = 0.
  - err_count, first_err_idx, bit counter, hold counter = 0.
- All outputs are registered.
- States: IDLE, FILL, HOLD, READOUT, DONE.
- IDLE:
  - On start=1: latch pattern_sel and hold_cycles.
  - Clear err_count, err_flag and first_err_idx.
  - Set k=0 and go to FILL.
  - start during any other state is ignored.
- FILL:
  - sr_mode=1, sr_data_in = pat(k).
  - k increments every cycle.
  - After LENGTH cycles (k=LENGTH-1 shifted), go to HOLD, or straight to READOUT if the latched hold_cycles=0.
  - At that point bit 0 of the pattern is at the chain MSB.
- HOLD:
  - sr_mode=0; the hold counter counts latched hold_cycles cycles.
  - Then set k=0 and go to READOUT.
- READOUT:
  - sr_mode=1 for LENGTH cycles.
  - At each shifting edge k, sample sr_data_out and compare it with pat(k).
  - Simultaneously drive sr_data_in=pat(k), so the chain is reloaded with the same pattern.
  - On mismatch: err_count += 1, saturating at 2^CNT_W-1.
  - On the first mismatch only: err_flag=1 and first_err_idx=k.
- DONE:
  - One cycle with sr_mode=0 and done=1, then IDLE.
  - Results hold until the next start.
- Pattern: pat(k) is a pure function of k and the latched pattern_sel; no wrap of k beyond LENGTH-1.
- Pipeline order: the chain's data_out at the edge is pre-shift, so the comparison uses the current-cycle value with no pipeline delay.
- Abort in any busy state:
  - Next cycle IDLE, sr_mode=0, no done pulse.
  - err_count and err_flag keep their partial values.
- Reset mid-run: immediate return to reset values; chain contents are undefined.
- Total run latency, start to done: 1 + LENGTH + hold_cycles + LENGTH + 1 cycles.

Optional Feature:
- Macro: SEU_SHIFT_REG_TESTER_CONT_EN.
- Defined:
  - After READOUT, pulse done and go directly to HOLD, since the chain was reloaded during readout.
  - This loops indefinitely until abort; err_count accumulates across loops and is not cleared.
  - first_err_idx keeps the first error ever seen.
- Undefined: single run as described above.

Decomposition:
- Shared package seu_test_pkg:
  - state encoding localparams (IDLE=0 … DONE=4).
  - pattern_sel codes.
  - pat(k, sel) function.
- One natural sub-module: seu_pattern_gen, a combinational pattern bit from k and sel, reused by both fill and compare.

Test Plan:
1. LENGTH=50, pattern_sel=2, hold_cycles=10, start; chain model healthy → done 112 cycles after start edge, err_count=0, err_flag=0.
2. Same setup, flip chain bit 37 during HOLD → readout index k=12 (bit 37 holds pattern bit 12) mismatches; err_count=1, first_err_idx=12.
3. pattern_sel=1, flip chain bits 5, 20, 44 during HOLD → err_count=3, first_err_idx=5 (bit 44 is read first, k=5).
4. hold_cycles=0, pattern_sel=3 → HOLD skipped; done after 102 cycles; after the run the chain again contains the pattern (second run gives err_count=0).
5. CNT_W=2, pattern_sel=0, force sr_data_out=1 → err_count saturates at 3, err_flag=1, first_err_idx=0.
6. Assert abort in HOLD, and separately rst_n=0 during READOUT → IDLE next cycle, sr_mode=0, no done pulse; rst_n case shows all outputs at 0.
